frame_capture_buffer: RTL and testbench

//  Parametrised single-clock successor of the uplink dataframe store. Captures wide frames
//  (e.g. 234-bit lpGBT user data, already in the register clock domain) into a show-ahead FIFO.

---
 rtl/frame_capture_buffer_pkg.sv | 19 +
 rtl/frame_capture_buffer_fifo.sv | 74 +++++++
 rtl/frame_capture_buffer.sv | 177 +++++++++++++++++
 tb/tb_frame_capture_buffer.sv | 396 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/frame_capture_buffer_pkg.sv
// Shared types and helpers for the frame capture buffer: capture-state
// encoding, mode constants and the slice-count helper.
package frame_capture_buffer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CAPTURE = 2'd1,
    ST_DONE    = 2'd2
  } cap_state_t;

  localparam logic MODE_CONT    = 1'b0;
  localparam logic MODE_ONESHOT = 1'b1;

  // Number of WORD_W slices needed to cover one frame (ceiling division).
  function automatic int nwords(input int frame_w, input int word_w);
    return (frame_w + word_w - 1) / word_w;
  endfunction

endpackage

// File: rtl/frame_capture_buffer_fifo.sv
// Single-clock show-ahead FIFO: the head entry is always visible on
// o_rd_data. Level and flags are registered and reflect the contents after
// the most recent clock edge. A write into a full FIFO is accepted only when a
// read retires the head in the same cycle.
module frame_capture_buffer_fifo #(
  parameter int DEPTH  = 16,
  parameter int DATA_W = 234
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     i_wr_en,
  input  logic [DATA_W-1:0]        i_wr_data,
  input  logic                     i_rd_en,
  output logic                     o_wr_ack,
  output logic [DATA_W-1:0]        o_rd_data,
  output logic [$clog2(DEPTH):0]   o_level,
  output logic                     o_full,
  output logic                     o_empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = PTR_W + 1;

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [LVL_W-1:0]  r_level;
  logic              r_full;
  logic              r_empty;

  logic              w_do_push;
  logic              w_do_pop;
  logic [LVL_W-1:0]  w_level_nxt;

  // A read of an empty FIFO is ignored; a write to a full FIFO needs a read.
  assign w_do_pop    = i_rd_en && !r_empty;
  assign w_do_push   = i_wr_en && (!r_full || w_do_pop);
  assign w_level_nxt = r_level + LVL_W'(w_do_push) - LVL_W'(w_do_pop);

  assign o_wr_ack  = w_do_push;
  assign o_rd_data = r_mem[r_rd_ptr];
  assign o_level   = r_level;
  assign o_full    = r_full;
  assign o_empty   = r_empty;

  // Frame storage write port.
  // NOTE: the storage array is deliberately not reset; validity is tracked by
  // the pointers and level, and leaving it unreset lets it map onto RAM.
  always_ff @(posedge clk) begin
    if (w_do_push) begin
      r_mem[r_wr_ptr] <= i_wr_data;
    end
  end

  // Pointers (wrapping modulo DEPTH), level and registered flags.
  // NOTE: all sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
      r_full   <= 1'b0;
      r_empty  <= 1'b1;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      r_level <= w_level_nxt;
      r_full  <= (w_level_nxt == LVL_W'(DEPTH));
      r_empty <= (w_level_nxt == '0);
    end
  end

endmodule

// File: rtl/frame_capture_buffer.sv
// Frame capture buffer: captures wide frames into a show-ahead FIFO and
// presents the head frame as WORD_W-bit slices for a register bank.
// Continuous and one-shot capture, occupancy level, saturating overflow
// count and capture-done status.
// Optional feature macro FCB_TIMESTAMP_EN: stores a free-running CNT_W
// timestamp with every frame, readable at word_sel_i == NWORDS.
module frame_capture_buffer
  import frame_capture_buffer_pkg::*;
#(
  parameter int FRAME_W = 234,
  parameter int WORD_W  = 32,
  parameter int DEPTH   = 16,
  parameter int CNT_W   = 16
) (
  input  logic                                         S_AXI_ACLK,
  input  logic                                         S_AXI_ARESETN,
  input  logic [FRAME_W-1:0]                           frame_i,
  input  logic                                         frame_valid_i,
  input  logic                                         enable_i,
  input  logic                                         mode_i,
  input  logic                                         arm_i,
  input  logic [CNT_W-1:0]                             capture_len_i,
  input  logic [$clog2(nwords(FRAME_W, WORD_W)+1)-1:0] word_sel_i,
  input  logic                                         pop_i,
  output logic [WORD_W-1:0]                            word_o,
  output logic [$clog2(DEPTH):0]                       level_o,
  output logic                                         full_o,
  output logic                                         empty_o,
  output logic [CNT_W-1:0]                             overflow_cnt_o,
  output logic                                         done_o
);

  localparam int NWORDS = nwords(FRAME_W, WORD_W);
  localparam int SEL_W  = $clog2(NWORDS + 1);
  localparam int PAD_W  = NWORDS * WORD_W;
`ifdef FCB_TIMESTAMP_EN
  localparam int FIFO_W = FRAME_W + CNT_W;
`else
  localparam int FIFO_W = FRAME_W;
`endif

  cap_state_t          r_state;
  logic                r_done;
  logic [CNT_W-1:0]    r_captured;
  logic [CNT_W-1:0]    r_len;
  logic [CNT_W-1:0]    r_ovf;
  logic [WORD_W-1:0]   r_word;

  logic                w_push_req;
  logic                w_wr_ack;
  logic                w_dropped;
  logic [CNT_W-1:0]    w_cap_next;
  logic [FIFO_W-1:0]   w_fifo_wdata;
  logic [FIFO_W-1:0]   w_head;
  logic [PAD_W-1:0]    w_padded;
  logic [WORD_W-1:0]   w_slice;

  // Frames are taken only while capturing. In one-shot mode the run stops
  // accepting once the requested count is reached, and the arm cycle itself
  // accepts nothing so every counted frame belongs to the new run.
  assign w_push_req = frame_valid_i && (r_state == ST_CAPTURE) &&
                      !((mode_i == MODE_ONESHOT) && (arm_i || (r_captured == r_len)));
  assign w_dropped  = w_push_req && !w_wr_ack;
  assign w_cap_next = r_captured + CNT_W'(w_wr_ack);

`ifdef FCB_TIMESTAMP_EN
  logic [CNT_W-1:0] r_ts;

  // Free-running timestamp stored alongside each captured frame.
  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) r_ts <= '0;
    else                r_ts <= r_ts + CNT_W'(1);
  end

  assign w_fifo_wdata = {r_ts, frame_i};
`else
  assign w_fifo_wdata = frame_i;
`endif

  frame_capture_buffer_fifo #(
    .DEPTH  (DEPTH),
    .DATA_W (FIFO_W)
  ) u_fifo (
    .clk       (S_AXI_ACLK),
    .rst_n     (S_AXI_ARESETN),
    .i_wr_en   (w_push_req),
    .i_wr_data (w_fifo_wdata),
    .i_rd_en   (pop_i),
    .o_wr_ack  (w_wr_ack),
    .o_rd_data (w_head),
    .o_level   (level_o),
    .o_full    (full_o),
    .o_empty   (empty_o)
  );

  // Capture FSM with registered done flag; dropping enable always wins.
  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      r_state <= ST_IDLE;
      r_done  <= 1'b0;
    end else if (!enable_i) begin
      r_state <= ST_IDLE;
      r_done  <= 1'b0;
    end else if (arm_i && (mode_i == MODE_ONESHOT) && (capture_len_i == '0)) begin
      r_state <= ST_DONE;
      r_done  <= 1'b1;
    end else if (arm_i) begin
      r_state <= ST_CAPTURE;
      r_done  <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (mode_i == MODE_CONT) r_state <= ST_CAPTURE;
        end
        ST_CAPTURE: begin
          if ((mode_i == MODE_ONESHOT) && (w_cap_next == r_len)) begin
            r_state <= ST_DONE;
            r_done  <= 1'b1;
          end
        end
        ST_DONE: begin
          r_done <= 1'b1;
        end
        default: begin
          r_state <= ST_IDLE;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

  // Run bookkeeping: captured count, sampled run length, saturating drops.
  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      r_captured <= '0;
      r_len      <= '0;
      r_ovf      <= '0;
    end else if (arm_i) begin
      r_captured <= '0;
      r_len      <= capture_len_i;
      r_ovf      <= '0;
    end else begin
      r_captured <= w_cap_next;
      if (w_dropped && (r_ovf != '1)) r_ovf <= r_ovf + CNT_W'(1);
    end
  end

  // Head frame zero-extended to a whole number of slices.
  always_comb begin
    w_padded = '0;
    w_padded[FRAME_W-1:0] = w_head[FRAME_W-1:0];
  end

  // Slice select; unmapped indices read zero.
  // NOTE: w_slice gets a default before the loop so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    w_slice = '0;
    for (int i = 0; i < NWORDS; i++) begin
      if (word_sel_i == SEL_W'(i)) w_slice = w_padded[i*WORD_W +: WORD_W];
    end
`ifdef FCB_TIMESTAMP_EN
    if (word_sel_i == SEL_W'(NWORDS)) w_slice = WORD_W'(w_head[FIFO_W-1 -: CNT_W]);
`endif
  end

  // Registered readout; an empty FIFO reads zero.
  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) r_word <= '0;
    else                r_word <= empty_o ? '0 : w_slice;
  end

  assign word_o         = r_word;
  assign overflow_cnt_o = r_ovf;
  assign done_o         = r_done;

endmodule

// File: tb/tb_frame_capture_buffer.sv
// Directed testbench for frame_capture_buffer at default parameters.
// Inputs change and outputs are sampled on the falling clock edge.
`timescale 1ns/1ps
module tb_frame_capture_buffer;

  localparam int FRAME_W = 234;
  localparam int WORD_W  = 32;
  localparam int DEPTH   = 16;
  localparam int CNT_W   = 16;
  localparam int NWORDS  = 8;
  localparam int SEL_W   = 4;
  localparam int LVL_W   = 5;

  logic                S_AXI_ACLK = 1'b0;
  logic                S_AXI_ARESETN;
  logic [FRAME_W-1:0]  frame_i;
  logic                frame_valid_i;
  logic                enable_i;
  logic                mode_i;
  logic                arm_i;
  logic [CNT_W-1:0]    capture_len_i;
  logic [SEL_W-1:0]    word_sel_i;
  logic                pop_i;
  logic [WORD_W-1:0]   word_o;
  logic [LVL_W-1:0]    level_o;
  logic                full_o;
  logic                empty_o;
  logic [CNT_W-1:0]    overflow_cnt_o;
  logic                done_o;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 S_AXI_ACLK = ~S_AXI_ACLK;

  frame_capture_buffer #(
    .FRAME_W (FRAME_W),
    .WORD_W  (WORD_W),
    .DEPTH   (DEPTH),
    .CNT_W   (CNT_W)
  ) dut (
    .S_AXI_ACLK     (S_AXI_ACLK),
    .S_AXI_ARESETN  (S_AXI_ARESETN),
    .frame_i        (frame_i),
    .frame_valid_i  (frame_valid_i),
    .enable_i       (enable_i),
    .mode_i         (mode_i),
    .arm_i          (arm_i),
    .capture_len_i  (capture_len_i),
    .word_sel_i     (word_sel_i),
    .pop_i          (pop_i),
    .word_o         (word_o),
    .level_o        (level_o),
    .full_o         (full_o),
    .empty_o        (empty_o),
    .overflow_cnt_o (overflow_cnt_o),
    .done_o         (done_o)
  );

  // Frame n: every 32-bit slice k is {n, k, 16'hA5C3}, truncated to 234 bits.
  function automatic logic [FRAME_W-1:0] mk_frame(input int n);
    logic [255:0] t;
    for (int k = 0; k < 8; k++) t[k*32 +: 32] = {8'(n), 8'(k), 16'hA5C3};
    return t[FRAME_W-1:0];
  endfunction

  function automatic logic [31:0] slice0(input int n);
    return {8'(n), 24'h00A5C3};
  endfunction

  task automatic idle_inputs();
    frame_i       = '0;
    frame_valid_i = 1'b0;
    enable_i      = 1'b0;
    mode_i        = 1'b0;
    arm_i         = 1'b0;
    capture_len_i = '0;
    word_sel_i    = '0;
    pop_i         = 1'b0;
  endtask

  // Ends at the falling edge on which reset is released (cycle 0).
  task automatic do_reset();
    idle_inputs();
    S_AXI_ARESETN = 1'b0;
    repeat (2) @(posedge S_AXI_ACLK);
    @(negedge S_AXI_ACLK);
    S_AXI_ARESETN = 1'b1;
  endtask

  task automatic start_cont();
    enable_i = 1'b1;
    mode_i   = 1'b0;
    @(negedge S_AXI_ACLK);
  endtask

  task automatic push_frame(input logic [FRAME_W-1:0] f);
    frame_i       = f;
    frame_valid_i = 1'b1;
    @(negedge S_AXI_ACLK);
    frame_valid_i = 1'b0;
  endtask

  task automatic pop_one();
    pop_i = 1'b1;
    @(negedge S_AXI_ACLK);
    pop_i = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    n_tests++;
    if ({word_o, level_o, full_o, empty_o, overflow_cnt_o, done_o} !==
        {32'h0, 5'd0, 1'b0, 1'b1, 16'h0, 1'b0}) begin
      n_fail++;
      $display("FAIL reset_state: word=%h level=%0d full=%b empty=%b ovf=%0d done=%b, want 0/0/0/1/0/0",
               word_o, level_o, full_o, empty_o, overflow_cnt_o, done_o);
    end
  endtask

  task automatic test_reset_mid_capture();
    do_reset();
    start_cont();
    for (int n = 0; n < 5; n++) push_frame(mk_frame(n));
    @(negedge S_AXI_ACLK);
    n_tests++;
    if (level_o !== 5'd5 || word_o !== slice0(0)) begin
      n_fail++;
      $display("FAIL pre_reset: level=%0d word=%h, want 5 %h", level_o, word_o, slice0(0));
    end
    #2 S_AXI_ARESETN = 1'b0;
    #1;
    n_tests++;
    if (empty_o !== 1'b1 || level_o !== 5'd0 || word_o !== 32'h0 || done_o !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_mid_capture: empty=%b level=%0d word=%h done=%b, want 1 0 0 0",
               empty_o, level_o, word_o, done_o);
    end
    idle_inputs();
    @(negedge S_AXI_ACLK);
    S_AXI_ARESETN = 1'b1;
  endtask

  task automatic test_slices();
    logic [31:0]  pat [8];
    logic [255:0] t;
    logic [31:0]  exp_w;
    pat = '{32'hAB0000CD, 32'hAB1111CD, 32'hAB2222CD, 32'hAB3333CD,
            32'hAB4444CD, 32'hAB5555CD, 32'hAB6666CD, 32'hFFFFFFCD};
    for (int k = 0; k < 8; k++) t[k*32 +: 32] = pat[k];
    do_reset();
    start_cont();
    push_frame(t[FRAME_W-1:0]);
    n_tests++;
    if (level_o !== 5'd1 || empty_o !== 1'b0) begin
      n_fail++;
      $display("FAIL slices_level: level=%0d empty=%b, want 1 0", level_o, empty_o);
    end
    for (int s = 0; s < NWORDS; s++) begin
      word_sel_i = SEL_W'(s);
      @(negedge S_AXI_ACLK);
      exp_w = (s == 7) ? 32'h000003CD : pat[s];
      n_tests++;
      if (word_o !== exp_w) begin
        n_fail++;
        $display("FAIL slice_%0d: got %h want %h", s, word_o, exp_w);
      end
    end
`ifndef FCB_TIMESTAMP_EN
    word_sel_i = SEL_W'(NWORDS);
    @(negedge S_AXI_ACLK);
    n_tests++;
    if (word_o !== 32'h0) begin
      n_fail++;
      $display("FAIL slice_nwords: got %h want 0", word_o);
    end
`endif
    word_sel_i = '0;
    pop_one();
    n_tests++;
    if (level_o !== 5'd0 || empty_o !== 1'b1) begin
      n_fail++;
      $display("FAIL slices_pop: level=%0d empty=%b, want 0 1", level_o, empty_o);
    end
    @(negedge S_AXI_ACLK);
    n_tests++;
    if (word_o !== 32'h0) begin
      n_fail++;
      $display("FAIL empty_read: got %h want 0", word_o);
    end
  endtask

  // Leaves the FIFO full (frames 0..15) for test_full_push_pop.
  task automatic test_overflow();
    do_reset();
    start_cont();
    for (int n = 0; n < 20; n++) push_frame(mk_frame(n));
    n_tests++;
    if (full_o !== 1'b1 || level_o !== 5'd16 || overflow_cnt_o !== 16'd4) begin
      n_fail++;
      $display("FAIL overflow: full=%b level=%0d ovf=%0d, want 1 16 4", full_o, level_o, overflow_cnt_o);
    end
    @(negedge S_AXI_ACLK);
    n_tests++;
    if (word_o !== slice0(0)) begin
      n_fail++;
      $display("FAIL overflow_head: got %h want %h", word_o, slice0(0));
    end
  endtask

  task automatic test_full_push_pop();
    int exp_n;
    frame_i       = mk_frame(99);
    frame_valid_i = 1'b1;
    pop_i         = 1'b1;
    @(negedge S_AXI_ACLK);
    frame_valid_i = 1'b0;
    pop_i         = 1'b0;
    n_tests++;
    if (level_o !== 5'd16 || full_o !== 1'b1 || overflow_cnt_o !== 16'd4) begin
      n_fail++;
      $display("FAIL full_push_pop: level=%0d full=%b ovf=%0d, want 16 1 4", level_o, full_o, overflow_cnt_o);
    end
    @(negedge S_AXI_ACLK);
    // Expected order: frames 1..15, then the frame pushed while full.
    for (int i = 0; i < 16; i++) begin
      exp_n = (i < 15) ? i + 1 : 99;
      n_tests++;
      if (word_o !== slice0(exp_n)) begin
        n_fail++;
        $display("FAIL drain_%0d: got %h want %h", i, word_o, slice0(exp_n));
      end
      pop_one();
      @(negedge S_AXI_ACLK);
    end
    n_tests++;
    if (level_o !== 5'd0 || empty_o !== 1'b1 || full_o !== 1'b0) begin
      n_fail++;
      $display("FAIL drained: level=%0d empty=%b full=%b, want 0 1 0", level_o, empty_o, full_o);
    end
  endtask

  task automatic test_oneshot();
    do_reset();
    enable_i      = 1'b1;
    mode_i        = 1'b1;
    capture_len_i = 16'd3;
    arm_i         = 1'b1;
    @(negedge S_AXI_ACLK);
    arm_i = 1'b0;
    for (int n = 0; n < 6; n++) begin
      push_frame(mk_frame(n));
      if (n == 1) begin
        n_tests++;
        if (done_o !== 1'b0 || level_o !== 5'd2) begin
          n_fail++;
          $display("FAIL oneshot_2nd: done=%b level=%0d, want 0 2", done_o, level_o);
        end
      end
      if (n == 2) begin
        n_tests++;
        if (done_o !== 1'b1 || level_o !== 5'd3) begin
          n_fail++;
          $display("FAIL oneshot_3rd: done=%b level=%0d, want 1 3", done_o, level_o);
        end
      end
    end
    n_tests++;
    if (done_o !== 1'b1 || level_o !== 5'd3 || overflow_cnt_o !== 16'd0) begin
      n_fail++;
      $display("FAIL oneshot_6: done=%b level=%0d ovf=%0d, want 1 3 0", done_o, level_o, overflow_cnt_o);
    end
    arm_i = 1'b1;
    @(negedge S_AXI_ACLK);
    arm_i = 1'b0;
    n_tests++;
    if (done_o !== 1'b0) begin
      n_fail++;
      $display("FAIL rearm_done: got %b want 0", done_o);
    end
    for (int n = 6; n < 10; n++) push_frame(mk_frame(n));
    n_tests++;
    if (done_o !== 1'b1 || level_o !== 5'd6) begin
      n_fail++;
      $display("FAIL rearm_run: done=%b level=%0d, want 1 6", done_o, level_o);
    end
    @(negedge S_AXI_ACLK);
    n_tests++;
    if (word_o !== slice0(0)) begin
      n_fail++;
      $display("FAIL oneshot_head: got %h want %h", word_o, slice0(0));
    end
  endtask

  task automatic test_len_zero();
    do_reset();
    enable_i      = 1'b1;
    mode_i        = 1'b1;
    capture_len_i = 16'd0;
    arm_i         = 1'b1;
    @(negedge S_AXI_ACLK);
    arm_i = 1'b0;
    n_tests++;
    if (done_o !== 1'b1) begin
      n_fail++;
      $display("FAIL len_zero_done: got %b want 1", done_o);
    end
    push_frame(mk_frame(1));
    n_tests++;
    if (level_o !== 5'd0) begin
      n_fail++;
      $display("FAIL len_zero_level: got %0d want 0", level_o);
    end
    enable_i = 1'b0;
    @(negedge S_AXI_ACLK);
    n_tests++;
    if (done_o !== 1'b0) begin
      n_fail++;
      $display("FAIL disable_done: got %b want 0", done_o);
    end
  endtask

  task automatic test_pop_empty();
    do_reset();
    start_cont();
    pop_one();
    n_tests++;
    if (level_o !== 5'd0 || empty_o !== 1'b1) begin
      n_fail++;
      $display("FAIL pop_empty: level=%0d empty=%b, want 0 1", level_o, empty_o);
    end
    frame_i       = mk_frame(7);
    frame_valid_i = 1'b1;
    pop_i         = 1'b1;
    @(negedge S_AXI_ACLK);
    frame_valid_i = 1'b0;
    pop_i         = 1'b0;
    n_tests++;
    if (level_o !== 5'd1 || empty_o !== 1'b0) begin
      n_fail++;
      $display("FAIL push_pop_empty: level=%0d empty=%b, want 1 0", level_o, empty_o);
    end
    enable_i = 1'b0;
    @(negedge S_AXI_ACLK);
    push_frame(mk_frame(8));
    push_frame(mk_frame(9));
    n_tests++;
    if (level_o !== 5'd1 || overflow_cnt_o !== 16'd0) begin
      n_fail++;
      $display("FAIL idle_ignore: level=%0d ovf=%0d, want 1 0", level_o, overflow_cnt_o);
    end
  endtask

`ifdef FCB_TIMESTAMP_EN
  task automatic test_timestamp();
    do_reset();
    enable_i = 1'b1;
    mode_i   = 1'b0;
    repeat (10) @(negedge S_AXI_ACLK);
    push_frame(mk_frame(1));
    repeat (2) @(negedge S_AXI_ACLK);
    push_frame(mk_frame(2));
    word_sel_i = SEL_W'(NWORDS);
    @(negedge S_AXI_ACLK);
    n_tests++;
    if (word_o !== 32'd10) begin
      n_fail++;
      $display("FAIL timestamp_first: got %0d want 10", word_o);
    end
    pop_one();
    @(negedge S_AXI_ACLK);
    n_tests++;
    if (word_o !== 32'd13) begin
      n_fail++;
      $display("FAIL timestamp_second: got %0d want 13", word_o);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_reset_mid_capture();
    test_slices();
    test_overflow();
    test_full_push_pop();
    test_oneshot();
    test_len_zero();
    test_pop_empty();
`ifdef FCB_TIMESTAMP_EN
    test_timestamp();
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
